uart_frame_parser: RTL and testbench
====================================

// Module: uart_frame_parser
// PURPOSE
//  Downstream stage of the UART receiver: consumes its 1-cycle byte strobe and byte,
//  hunts a start-of-frame byte, collects LEN + payload + XOR checksum, then buffers the
//  payload for the consumer. Sits between uart_rx and the command/config logic.
// PARAMETERS
//  MAX_LEN       16      max payload bytes held in buffer (1..255)
//  SOF_BYTE      8'hA5   start-of-frame marker
//  TIMEOUT_CLKS  104160  max clocks between bytes inside a frame (2 byte-times @5208)
// PORTS
//  i_Clock        in   1   system clock
//  i_Rst_n        in   1   reset, asynchronous, active-low
//  i_Enable       in   1   block enable; low = synchronous return to IDLE
//  i_Rx_DV        in   1   byte strobe from uart_rx (1 cycle)
//  i_Rx_Byte      in   8   received byte, valid with i_Rx_DV
//  o_Frame_Valid  out  1   complete good frame held; high until i_Frame_Ack
//  i_Frame_Ack    in   1   consumer releases frame
//  o_Frame_Len    out  8   payload length of held frame
//  i_Rd_Addr      in   $clog2(MAX_LEN)  payload read index
//  o_Rd_Data      out  8   payload[i_Rd_Addr], combinational; 8'h00 if i_Rd_Addr>=o_Frame_Len
//  o_Busy         out  1   state != IDLE
//  o_Err_Chk      out  1   1-cycle pulse: checksum mismatch
//  o_Err_Len      out  1   1-cycle pulse: LEN > MAX_LEN
//  o_Err_Timeout  out  1   1-cycle pulse: inter-byte timeout
//  o_Err_Overrun  out  1   1-cycle pulse: byte dropped while frame held
// BEHAVIOUR
//  Reset: state IDLE, counters/checksum 0, all outputs 0; payload buffer not reset.
//  States: IDLE -> LEN -> PAYLOAD -> CHK -> HOLD -> IDLE. Only i_Rx_DV cycles advance.
//  IDLE: byte==SOF_BYTE -> LEN; any other byte ignored silently.
//  LEN: latch len, chk=len. len>MAX_LEN -> o_Err_Len, IDLE. len==0 -> CHK; else PAYLOAD.
//  PAYLOAD: buf[idx]=byte, chk^=byte, idx++; after len-th byte -> CHK.
//  CHK: byte==chk -> HOLD, o_Frame_Valid=1 the cycle after the strobe (latency 1);
//   else o_Err_Chk pulse, IDLE.
//  HOLD: o_Frame_Valid, o_Frame_Len, buffer stable. i_Rx_DV without ack -> byte dropped,
//   o_Err_Overrun pulse. i_Frame_Ack -> o_Frame_Valid low next cycle; ack and i_Rx_DV
//   same cycle -> byte evaluated as IDLE (SOF -> LEN), no overrun.
//  Timeout: in LEN/PAYLOAD/CHK a counter clears on each i_Rx_DV, increments otherwise;
//   reaching TIMEOUT_CLKS-1 -> o_Err_Timeout pulse, IDLE. Not active in IDLE/HOLD.
//  Strobe and timeout same cycle: strobe wins, counter clears.
//  i_Enable low: IDLE, counters 0, o_Frame_Valid 0, pulses 0 (held frame discarded).
//  Reset mid-frame: immediate IDLE; partial frame discarded, no error pulse.
//  Widths: idx $clog2(MAX_LEN+1); timeout counter $clog2(TIMEOUT_CLKS); chk 8-bit XOR.
//  At most one error pulse per cycle.
// STRUCTURE
//  uart_pkg: parser_state_t enum {P_IDLE,P_LEN,P_PAYLOAD,P_CHK,P_HOLD},
//   localparam UART_SOF_DEFAULT=8'hA5 (shared with future uart frame builder).
//  Sub-module uart_frame_buf: MAX_LEN x 8 register file, 1 sync write, 1 async read.
//  FSM, checksum, timeout counter in top module.
// TESTING (bench TIMEOUT_CLKS=64, MAX_LEN=16, strobes 10 clocks apart)
//  1 A5 03 11 22 33 03 -> o_Frame_Valid 1 cycle after last strobe, len 3,
//    addr0..2 = 11 22 33, addr3 = 00; ack -> valid low next cycle.
//  2 A5 02 AA 55 00 (expect FD) -> one o_Err_Chk pulse, no valid, o_Busy low.
//  3 A5 11 -> o_Err_Len pulse; then A5 01 7E 7F -> valid, len 1, data 7E.
//  4 A5 02 10 then 64 idle clocks -> o_Err_Timeout once; later 00 ignored, stays IDLE.
//  5 frame held, send 42 -> o_Err_Overrun, data unchanged; ack with A5 same cycle -> LEN.
//  6 A5 00 00 -> valid len 0; i_Rst_n low mid-PAYLOAD -> IDLE, all outputs 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART frame parser and the frame builder.
package uart_pkg;
   typedef enum logic [2:0] {P_IDLE, P_LEN, P_PAYLOAD, P_CHK, P_HOLD} parser_state_t;
   localparam logic [7:0] UART_SOF_DEFAULT = 8'hA5;
endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: payload register file, one synchronous write port and one asynchronous read port.
module uart_frame_buf #(
   parameter int DEPTH = 16,
   parameter int AW = 4
) (
   input  logic          i_Clock,
   input  logic          i_Wr_En,
   input  logic [AW-1:0] i_Wr_Addr,
   input  logic [7:0]    i_Wr_Data,
   input  logic [AW-1:0] i_Rd_Addr,
   output logic [7:0]    o_Rd_Data
);
   logic [7:0] mem [DEPTH];
   always_ff @(posedge i_Clock)
      if (i_Wr_En) mem[i_Wr_Addr] <= i_Wr_Data;
   assign o_Rd_Data = mem[i_Rd_Addr];
endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: hunts SOF, collects LEN + payload + XOR checksum from uart_rx bytes,
// and holds a good frame for the consumer until acknowledged.
module uart_frame_parser import uart_pkg::*; #(
   parameter int MAX_LEN = 16,
   parameter logic [7:0] SOF_BYTE = UART_SOF_DEFAULT,
   parameter int TIMEOUT_CLKS = 104160,
   localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1
) (
   input  logic          i_Clock,
   input  logic          i_Rst_n,
   input  logic          i_Enable,
   input  logic          i_Rx_DV,
   input  logic [7:0]    i_Rx_Byte,
   output logic          o_Frame_Valid,
   input  logic          i_Frame_Ack,
   output logic [7:0]    o_Frame_Len,
   input  logic [AW-1:0] i_Rd_Addr,
   output logic [7:0]    o_Rd_Data,
   output logic          o_Busy,
   output logic          o_Err_Chk,
   output logic          o_Err_Len,
   output logic          o_Err_Timeout,
   output logic          o_Err_Overrun
);
   localparam int IW = $clog2(MAX_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CLKS);
   localparam logic [7:0] MAX_B = 8'(MAX_LEN);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
   parser_state_t state, state_nxt;
   logic [7:0] len, chk, buf_rd;
   logic [IW-1:0] idx;
   logic [TW-1:0] cnt;
   logic in_frame, tmo, last, err_len_nxt, err_chk_nxt, err_ovr_nxt;
   assign in_frame = state inside {P_LEN, P_PAYLOAD, P_CHK};
   // A strobe in the same cycle always beats the timeout
   assign tmo = in_frame && !i_Rx_DV && cnt == TMO_LAST;
   assign last = 8'(idx) + 8'd1 == len;
   always_ff @(posedge i_Clock or negedge i_Rst_n)
      if (!i_Rst_n) state <= P_IDLE;
      else state <= i_Enable ? state_nxt : P_IDLE;
   always_comb begin
      state_nxt = state;
      err_len_nxt = 1'b0;
      err_chk_nxt = 1'b0;
      err_ovr_nxt = 1'b0;
      case (state)
         P_IDLE: state_nxt = (i_Rx_DV && i_Rx_Byte == SOF_BYTE) ? P_LEN : P_IDLE;
         P_LEN: if (i_Rx_DV) begin
            err_len_nxt = i_Rx_Byte > MAX_B;
            state_nxt = err_len_nxt ? P_IDLE : (i_Rx_Byte == 8'd0 ? P_CHK : P_PAYLOAD);
         end
         P_PAYLOAD: state_nxt = (i_Rx_DV && last) ? P_CHK : P_PAYLOAD;
         P_CHK: if (i_Rx_DV) begin
            err_chk_nxt = i_Rx_Byte != chk;
            state_nxt = err_chk_nxt ? P_IDLE : P_HOLD;
         end
         // An ack frees the parser in time to judge a coincident byte as a fresh SOF
         P_HOLD: begin
            err_ovr_nxt = i_Rx_DV && !i_Frame_Ack;
            state_nxt = !i_Frame_Ack ? P_HOLD : (i_Rx_DV && i_Rx_Byte == SOF_BYTE) ? P_LEN : P_IDLE;
         end
         default: state_nxt = P_IDLE;
      endcase
      if (tmo) state_nxt = P_IDLE;
   end
   always_comb begin
      o_Frame_Valid = state == P_HOLD;
      o_Busy = state != P_IDLE;
   end
   always_ff @(posedge i_Clock or negedge i_Rst_n)
      if (!i_Rst_n) begin
         len <= '0;
         chk <= '0;
         idx <= '0;
         cnt <= '0;
         o_Err_Chk <= 1'b0;
         o_Err_Len <= 1'b0;
         o_Err_Timeout <= 1'b0;
         o_Err_Overrun <= 1'b0;
      end else if (!i_Enable) begin
         len <= '0;
         chk <= '0;
         idx <= '0;
         cnt <= '0;
         o_Err_Chk <= 1'b0;
         o_Err_Len <= 1'b0;
         o_Err_Timeout <= 1'b0;
         o_Err_Overrun <= 1'b0;
      end else begin
         cnt <= (in_frame && !i_Rx_DV && !tmo) ? cnt + TW'(1) : '0;
         idx <= state == P_PAYLOAD ? idx + IW'(i_Rx_DV) : '0;
         if (i_Rx_DV && state == P_LEN) len <= i_Rx_Byte;
         chk <= !i_Rx_DV ? chk : state == P_LEN ? i_Rx_Byte : state == P_PAYLOAD ? chk ^ i_Rx_Byte : chk;
         o_Err_Chk <= err_chk_nxt;
         o_Err_Len <= err_len_nxt;
         o_Err_Timeout <= tmo;
         o_Err_Overrun <= err_ovr_nxt;
      end
   uart_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
      .i_Clock   (i_Clock),
      .i_Wr_En   (i_Enable && i_Rx_DV && state == P_PAYLOAD),
      .i_Wr_Addr (idx[AW-1:0]),
      .i_Wr_Data (i_Rx_Byte),
      .i_Rd_Addr (i_Rd_Addr),
      .o_Rd_Data (buf_rd)
   );
   assign o_Frame_Len = len;
   assign o_Rd_Data = 9'(i_Rd_Addr) < {1'b0, len} ? buf_rd : 8'h00;
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: directed scenarios plus randomized frames checked against a
// frame-level model (checksum = LEN xor payload bytes).
module tb_uart_frame_parser;
   localparam int MAX_LEN = 16;
   localparam int TMO = 64;
   logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, dv = 1'b0, ack = 1'b0;
   logic [7:0] rxb = 8'h00;
   logic [3:0] rd_addr = 4'd0;
   logic valid, busy, e_chk, e_len, e_tmo, e_ovr;
   logic [7:0] flen, rdata;
   int checks = 0, passed = 0;
   int n_chk = 0, n_len = 0, n_tmo = 0, n_ovr = 0;
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (e_chk) n_chk++;
      if (e_len) n_len++;
      if (e_tmo) n_tmo++;
      if (e_ovr) n_ovr++;
   end
   uart_frame_parser #(.MAX_LEN(MAX_LEN), .SOF_BYTE(8'hA5), .TIMEOUT_CLKS(TMO)) dut (
      .i_Clock       (clk),
      .i_Rst_n       (rst_n),
      .i_Enable      (en),
      .i_Rx_DV       (dv),
      .i_Rx_Byte     (rxb),
      .o_Frame_Valid (valid),
      .i_Frame_Ack   (ack),
      .o_Frame_Len   (flen),
      .i_Rd_Addr     (rd_addr),
      .o_Rd_Data     (rdata),
      .o_Busy        (busy),
      .o_Err_Chk     (e_chk),
      .o_Err_Len     (e_len),
      .o_Err_Timeout (e_tmo),
      .o_Err_Overrun (e_ovr)
   );
   task automatic strobe(input logic [7:0] b);
      dv = 1'b1;
      rxb = b;
      @(posedge clk); #1;
      dv = 1'b0;
   endtask
   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask
   task automatic send(input logic [7:0] b);
      strobe(b);
      idle(9);
   endtask
   task automatic do_ack();
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
   endtask
   task automatic test_reset();
      idle(3);
      checks++; if (valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", valid); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
      checks++; if (flen !== 8'h00) $display("FAIL reset_len got %h exp 00", flen); else passed++;
      checks++; if (rdata !== 8'h00) $display("FAIL reset_rdata got %h exp 00", rdata); else passed++;
      checks++; if ({e_chk, e_len, e_tmo, e_ovr} !== 4'b0) $display("FAIL reset_errs got %b exp 0000", {e_chk, e_len, e_tmo, e_ovr}); else passed++;
      rst_n = 1'b1;
      en = 1'b1;
      idle(2);
   endtask
   task automatic test_good_frame();
      logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h00};
      send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
      checks++; if (valid !== 1'b0) $display("FAIL good_early_valid got %b exp 0", valid); else passed++;
      strobe(8'h03);
      checks++; if (valid !== 1'b1) $display("FAIL good_valid got %b exp 1", valid); else passed++;
      checks++; if (flen !== 8'd3) $display("FAIL good_len got %h exp 03", flen); else passed++;
      for (int a = 0; a < 4; a++) begin
         rd_addr = 4'(a);
         #1;
         checks++; if (rdata !== exp_d[a]) $display("FAIL good_data[%0d] got %h exp %h", a, rdata, exp_d[a]); else passed++;
      end
      do_ack();
      checks++; if (valid !== 1'b0) $display("FAIL good_ack_valid got %b exp 0", valid); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL good_ack_busy got %b exp 0", busy); else passed++;
   endtask
   task automatic test_bad_chk();
      int c0 = n_chk;
      send(8'hA5); send(8'h02); send(8'hAA); send(8'h55); send(8'h00);
      checks++; if (n_chk - c0 !== 1) $display("FAIL badchk_pulses got %0d exp 1", n_chk - c0); else passed++;
      checks++; if (valid !== 1'b0) $display("FAIL badchk_valid got %b exp 0", valid); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL badchk_busy got %b exp 0", busy); else passed++;
   endtask
   task automatic test_bad_len();
      int l0 = n_len;
      send(8'hA5); send(8'h11);
      checks++; if (n_len - l0 !== 1) $display("FAIL badlen_pulses got %0d exp 1", n_len - l0); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL badlen_busy got %b exp 0", busy); else passed++;
      send(8'hA5); send(8'h01); send(8'h7E); strobe(8'h7F);
      rd_addr = 4'd0;
      #1;
      checks++; if (valid !== 1'b1) $display("FAIL len1_valid got %b exp 1", valid); else passed++;
      checks++; if (flen !== 8'd1) $display("FAIL len1_len got %h exp 01", flen); else passed++;
      checks++; if (rdata !== 8'h7E) $display("FAIL len1_data got %h exp 7e", rdata); else passed++;
      do_ack();
   endtask
   task automatic test_timeout();
      int t0 = n_tmo;
      send(8'hA5); send(8'h02); strobe(8'h10);
      idle(60);
      checks++; if (busy !== 1'b1) $display("FAIL tmo_early_busy got %b exp 1", busy); else passed++;
      checks++; if (n_tmo !== t0) $display("FAIL tmo_early_pulses got %0d exp 0", n_tmo - t0); else passed++;
      idle(10);
      checks++; if (n_tmo - t0 !== 1) $display("FAIL tmo_pulses got %0d exp 1", n_tmo - t0); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL tmo_busy got %b exp 0", busy); else passed++;
      send(8'h00);
      checks++; if (busy !== 1'b0) $display("FAIL tmo_idle_busy got %b exp 0", busy); else passed++;
      checks++; if (n_tmo - t0 !== 1) $display("FAIL tmo_idle_pulses got %0d exp 1", n_tmo - t0); else passed++;
   endtask
   task automatic test_overrun();
      int o0;
      send(8'hA5); send(8'h02); send(8'hC3); send(8'h3C); send(8'hFD);
      checks++; if (valid !== 1'b1) $display("FAIL ovr_setup_valid got %b exp 1", valid); else passed++;
      o0 = n_ovr;
      send(8'h42);
      checks++; if (n_ovr - o0 !== 1) $display("FAIL ovr_pulses got %0d exp 1", n_ovr - o0); else passed++;
      checks++; if (valid !== 1'b1) $display("FAIL ovr_valid got %b exp 1", valid); else passed++;
      checks++; if (flen !== 8'd2) $display("FAIL ovr_len got %h exp 02", flen); else passed++;
      rd_addr = 4'd0;
      #1;
      checks++; if (rdata !== 8'hC3) $display("FAIL ovr_data0 got %h exp c3", rdata); else passed++;
      rd_addr = 4'd1;
      #1;
      checks++; if (rdata !== 8'h3C) $display("FAIL ovr_data1 got %h exp 3c", rdata); else passed++;
      @(posedge clk); #1;
      ack = 1'b1;
      strobe(8'hA5);
      ack = 1'b0;
      checks++; if (valid !== 1'b0) $display("FAIL ackdv_valid got %b exp 0", valid); else passed++;
      checks++; if (busy !== 1'b1) $display("FAIL ackdv_busy got %b exp 1", busy); else passed++;
      idle(9);
      checks++; if (n_ovr - o0 !== 1) $display("FAIL ackdv_pulses got %0d exp 1", n_ovr - o0); else passed++;
      en = 1'b0;
      idle(1);
      checks++; if (busy !== 1'b0) $display("FAIL enable_busy got %b exp 0", busy); else passed++;
      en = 1'b1;
      idle(2);
   endtask
   task automatic test_zero_len_reset();
      int c0, l0, t0, o0;
      send(8'hA5); send(8'h00); strobe(8'h00);
      rd_addr = 4'd0;
      #1;
      checks++; if (valid !== 1'b1) $display("FAIL zero_valid got %b exp 1", valid); else passed++;
      checks++; if (flen !== 8'd0) $display("FAIL zero_len got %h exp 00", flen); else passed++;
      checks++; if (rdata !== 8'h00) $display("FAIL zero_data got %h exp 00", rdata); else passed++;
      do_ack();
      c0 = n_chk; l0 = n_len; t0 = n_tmo; o0 = n_ovr;
      send(8'hA5); send(8'h04); send(8'h01);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else passed++;
      checks++; if (valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", valid); else passed++;
      checks++; if (flen !== 8'h00) $display("FAIL rst_len got %h exp 00", flen); else passed++;
      idle(2);
      rst_n = 1'b1;
      idle(5);
      checks++; if ((n_chk - c0) + (n_len - l0) + (n_tmo - t0) + (n_ovr - o0) !== 0) $display("FAIL rst_pulses got %0d exp 0", (n_chk - c0) + (n_len - l0) + (n_tmo - t0) + (n_ovr - o0)); else passed++;
   endtask
   task automatic test_random();
      logic [7:0] pl [MAX_LEN];
      logic [7:0] sum, cb, jb;
      int len, c0, l0;
      bit bad;
      for (int f = 0; f < 40; f++) begin
         for (int j = $urandom_range(0, 2); j > 0; j--) begin
            jb = 8'($urandom);
            if (jb == 8'hA5) jb = 8'h5A;
            strobe(jb);
            idle($urandom_range(0, 12));
         end
         len = $urandom_range(0, MAX_LEN + 2);
         c0 = n_chk; l0 = n_len;
         strobe(8'hA5); idle($urandom_range(0, 12));
         strobe(8'(len)); idle($urandom_range(0, 12));
         if (len > MAX_LEN) begin
            idle(2);
            checks++; if (n_len - l0 !== 1) $display("FAIL rnd%0d_len_pulse got %0d exp 1", f, n_len - l0); else passed++;
            checks++; if (busy !== 1'b0) $display("FAIL rnd%0d_len_busy got %b exp 0", f, busy); else passed++;
            continue;
         end
         sum = 8'(len);
         for (int i = 0; i < len; i++) begin
            pl[i] = 8'($urandom);
            sum ^= pl[i];
            strobe(pl[i]);
            idle($urandom_range(0, 12));
         end
         bad = $urandom_range(0, 3) == 0;
         cb = bad ? sum ^ 8'($urandom_range(1, 255)) : sum;
         strobe(cb);
         checks++; if (valid !== !bad) $display("FAIL rnd%0d_valid got %b exp %b", f, valid, !bad); else passed++;
         idle(2);
         checks++; if (n_chk - c0 !== int'(bad)) $display("FAIL rnd%0d_chk_pulse got %0d exp %0d", f, n_chk - c0, int'(bad)); else passed++;
         if (bad) begin
            checks++; if (busy !== 1'b0) $display("FAIL rnd%0d_bad_busy got %b exp 0", f, busy); else passed++;
            continue;
         end
         checks++; if (flen !== 8'(len)) $display("FAIL rnd%0d_flen got %h exp %h", f, flen, 8'(len)); else passed++;
         for (int a = 0; a < MAX_LEN; a++) begin
            rd_addr = 4'(a);
            @(negedge clk);
            checks++; if (rdata !== (a < len ? pl[a] : 8'h00)) $display("FAIL rnd%0d_data[%0d] got %h exp %h", f, a, rdata, (a < len ? pl[a] : 8'h00)); else passed++;
         end
         @(posedge clk); #1;
         do_ack();
         checks++; if (valid !== 1'b0 || busy !== 1'b0) $display("FAIL rnd%0d_ack got valid %b busy %b exp 0 0", f, valid, busy); else passed++;
      end
   endtask
   initial begin
      test_reset();
      test_good_frame();
      test_bad_chk();
      test_bad_len();
      test_timeout();
      test_overrun();
      test_zero_len_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
